// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic unit.
//   state_e  : controller states (idle, running one bit per cycle, result pulse)
//   MODE_*   : operation select encoding for the mode input
//   maj3     : carry function of a single full-adder cell
package serial_arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/shift_register_nbit.sv
// Accumulator for the serial sum plus the final carry.
//   clk, rst   : clock, synchronous active-low reset
//   clr_i      : clear all bits (start of a new operation)
//   shift_i    : shift the sum field right, ser_i enters at bit N-2
//   msb_load_i : also load msb_i into bit N-1 (last bit of an operation)
//   q_o        : {carry, sum}; complete once the last shift has happened
module shift_register_nbit #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic         ser_i,
    input  logic         msb_load_i,
    input  logic         msb_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (shift_i) begin
            // Sum bits arrive LSB first, so after N-1 shifts bit 0 holds the sum LSB.
            q_d[N-2:0] = {ser_i, q_q[N-2:1]};
            if (msb_load_i) begin
                q_d[N-1] = msb_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
//   clk, rst        : clock, synchronous active-low reset
//   start           : request, accepted in idle or in the done cycle
//   mode            : 0 add, 1 subtract (a + ~b + 1); latched with start
//   data_a, data_b  : operands, latched with start
//   result          : {carry_out, sum}; holds the last completed value outside the done cycle
//   busy            : high while bits are being processed
//   done            : one-cycle pulse, result valid in that cycle
//   overflow        : signed overflow, only when SERIAL_ADDSUB_OVF_EN is defined
module serial_addsub_unit
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]    result_q, result_d;
    logic [WIDTH:0]    acc;
    logic              sum_bit, carry_out, last_bit, accept, run_shift;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = maj3(a_q[0], b_q[0], carry_q);
    assign last_bit  = (cnt_q == LastCnt);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        run_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                run_shift = 1'b1;
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                carry_d   = carry_out;
                cnt_d     = cnt_q + CntW'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d     = data_a;
            b_d     = (mode == MODE_ADD) ? data_b : ~data_b;
            carry_d = mode;  // +1 of the two's complement when subtracting
            cnt_d   = '0;
        end
    end

    shift_register_nbit #(
        .N (WIDTH + 1)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .shift_i    (run_shift),
        .ser_i      (sum_bit),
        .msb_load_i (run_shift & last_bit),
        .msb_i      (carry_out),
        .q_o        (acc)
    );

    // The accumulator is complete during the done cycle; copy it out then so the
    // visible result stays put while the next operation rebuilds the accumulator.
    always_comb begin
        result_d = result_q;
        if (state_q == StDone) begin
            result_d = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = (state_q == StDone) ? acc : result_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is the carry flop on the last bit; carry out is the cell output.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == StRun) && last_bit) begin
            ovf_d = carry_q ^ carry_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench: directed cases on an 8-bit unit, random sweep on 8- and 16-bit units.
module tb_serial_addsub_unit;
    import serial_arith_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, sel16;
    logic [31:0] data_a, data_b;
    logic        start8, start16;
    logic [8:0]  result8;
    logic [16:0] result16;
    logic        busy8, busy16, done8, done16;
    logic [32:0] result_s;
    logic        busy_s, done_s;

    int n_checks = 0;
    int n_pass   = 0;

    assign start8   = start & ~sel16;
    assign start16  = start & sel16;
    assign result_s = sel16 ? 33'(result16) : 33'(result8);
    assign busy_s   = sel16 ? busy16 : busy8;
    assign done_s   = sel16 ? done16 : done8;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf8, ovf16, ovf_s;
    assign ovf_s = sel16 ? ovf16 : ovf8;
`endif

    serial_addsub_unit #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .mode     (mode),
        .data_a   (data_a[7:0]),
        .data_b   (data_b[7:0]),
        .result   (result8),
        .busy     (busy8),
        .done     (done8)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .overflow (ovf8)
`endif
    );

    serial_addsub_unit #(.WIDTH(16)) u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .start    (start16),
        .mode     (mode),
        .data_a   (data_a[15:0]),
        .data_b   (data_b[15:0]),
        .result   (result16),
        .busy     (busy16),
        .done     (done16)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .overflow (ovf16)
`endif
    );

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Plain integer arithmetic: add is zero-extended sum, subtract is
    // {no_borrow, difference mod 2^w}.
    function automatic logic [32:0] ref_res(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic m);
        longint unsigned mask, ua, ub, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        if (m == MODE_ADD) r = ua + ub;
        else r = ((ua - ub) & mask) | ((ua >= ub) ? (64'd1 << w) : 64'd0);
        return 33'(r);
    endfunction

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed result outside the w-bit two's complement range.
    function automatic logic ref_ovf(input int unsigned w, input logic [31:0] a,
                                     input logic [31:0] b, input logic m);
        longint mask, half, sa, sb, r;
        mask = longint'((64'd1 << w) - 64'd1);
        half = longint'(64'd1 << (w - 1));
        sa   = longint'(64'(a)) & mask;
        sb   = longint'(64'(b)) & mask;
        if (sa >= half) sa = sa - 2 * half;
        if (sb >= half) sb = sb - 2 * half;
        r = (m == MODE_ADD) ? sa + sb : sa - sb;
        return (r >= half) || (r < -half);
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic m);
        data_a = a;
        data_b = b;
        mode   = m;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // lat counts clock edges since the start edge; bounded so a stuck unit still ends.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done_s !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic m);
        int          lat;
        int unsigned w;
        w = sel16 ? 16 : 8;
        launch(a, b, m);
        check_val({tag, "_busy"}, 33'(busy_s), 33'd1);
        wait_done(1, lat);
        check_val({tag, "_latency"}, 33'(lat), 33'(w + 1));
        check_val({tag, "_result"}, result_s, ref_res(w, a, b, m));
        check_val({tag, "_busy_at_done"}, 33'(busy_s), 33'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check_val({tag, "_ovf"}, 33'(ovf_s), 33'(ref_ovf(w, a, b, m)));
`endif
        tick();
        check_val({tag, "_done_single"}, 33'(done_s), 33'd0);
    endtask

    initial begin
        int   lat;
        logic saw_done;

        rst    = 1'b0;
        start  = 1'b0;
        mode   = MODE_ADD;
        sel16  = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) tick();
        check_val("rst_result8", 33'(result8), 33'd0);
        check_val("rst_result16", 33'(result16), 33'd0);
        check_val("rst_busy", 33'(busy8 | busy16), 33'd0);
        check_val("rst_done", 33'(done8 | done16), 33'd0);
        rst = 1'b1;
        tick();

        do_op("add_ff_01", 32'hFF, 32'h01, MODE_ADD);
        check_val("add_ff_01_const", result_s, 33'h100);
        do_op("sub_05_03", 32'h05, 32'h03, MODE_SUB);
        check_val("sub_05_03_const", result_s, 33'h102);
        do_op("sub_03_05", 32'h03, 32'h05, MODE_SUB);
        check_val("sub_03_05_const", result_s, 33'h0FE);
        do_op("add_7f_01", 32'h7F, 32'h01, MODE_ADD);
        do_op("sub_80_01", 32'h80, 32'h01, MODE_SUB);
        do_op("add_10_20", 32'h10, 32'h20, MODE_ADD);

        // Back-to-back: start held in the done cycle
        launch(32'h33, 32'h11, MODE_ADD);
        wait_done(1, lat);
        check_val("b2b_first", result_s, 33'h044);
        data_a = 32'h0A;
        data_b = 32'h05;
        mode   = MODE_ADD;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check_val("b2b_busy", 33'(busy_s), 33'd1);
        check_val("b2b_held", result_s, 33'h044);
        wait_done(1, lat);
        check_val("b2b_latency", 33'(lat), 33'd9);
        check_val("b2b_second", result_s, 33'h00F);
        tick();

        // start pulsed mid-run with other operands is ignored
        launch(32'h21, 32'h12, MODE_ADD);
        repeat (3) tick();
        check_val("midrun_held", result_s, 33'h00F);
        data_a = 32'hAA;
        data_b = 32'h55;
        mode   = MODE_SUB;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(5, lat);
        check_val("midrun_latency", 33'(lat), 33'd9);
        check_val("midrun_result", result_s, 33'h033);
        tick();

        // Reset in run cycle 4 aborts the operation
        launch(32'h44, 32'h22, MODE_SUB);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("abort_busy", 33'(busy_s), 33'd0);
        check_val("abort_done", 33'(done_s), 33'd0);
        check_val("abort_result", result_s, 33'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check_val("abort_ovf", 33'(ovf_s), 33'd0);
`endif
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done_s === 1'b1) saw_done = 1'b1;
            tick();
        end
        check_val("abort_no_done", 33'(saw_done), 33'd0);
        do_op("after_abort", 32'hC8, 32'h64, MODE_SUB);

        for (int i = 0; i < 20; i++) begin
            do_op("rand8", 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        sel16 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            do_op("rand16", 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        do_op("sub16_zero", 32'h0000, 32'hFFFF, MODE_SUB);
        do_op("add16_max", 32'hFFFF, 32'hFFFF, MODE_ADD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
